// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: issue/write-back bundle between the control unit, the
// register file and the iterative multiply/divide unit.
//   master (issuing side) drives : start, op, op_signed, operand_a, operand_b, rd_in
//   slave  (muldiv_unit)  drives : busy, done, regwrite, adr_wr_reg, wr_data
interface muldiv_unit_if #(
  parameter int XLEN = 64,
  parameter int AW   = 5
);
  logic            start;
  logic [1:0]      op;
  logic            op_signed;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic [AW-1:0]   rd_in;
  logic            busy;
  logic            done;
  logic            regwrite;
  logic [AW-1:0]   adr_wr_reg;
  logic [XLEN-1:0] wr_data;

  modport master (
    output start, op, op_signed, operand_a, operand_b, rd_in,
    input  busy, done, regwrite, adr_wr_reg, wr_data
  );

  modport slave (
    input  start, op, op_signed, operand_a, operand_b, rd_in,
    output busy, done, regwrite, adr_wr_reg, wr_data
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit, one result bit per cycle.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, aborts any operation in flight
//   bus  : muldiv_unit_if.slave
//          in : start, op (00 MUL, 01 MULH, 10 DIV, 11 REM), op_signed,
//               operand_a, operand_b, rd_in
//          out: busy, done, regwrite (= done), adr_wr_reg, wr_data
// Sequence: IDLE -> RUN (XLEN cycles) -> DONE (one cycle, write-back) -> IDLE.
// Optional feature macro: MULDIV_SIGNED_EN enables signed MULH/DIV/REM via
// magnitude conversion at start and sign correction when the result is formed.
// Without it op_signed is ignored and everything is unsigned.
module muldiv_unit #(
  parameter int XLEN = 64,
  parameter int AW   = 5
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MULH = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;
  localparam logic [1:0] OP_REM  = 2'b11;

  localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(XLEN - 1);

  state_t            state_r;
  logic [CW-1:0]     count_r;
  logic [1:0]        op_r;
  logic [AW-1:0]     rd_r;
  // Multiply: {high partial sum, multiplier shifting out}.
  // Divide:   {partial remainder, dividend shifting out / quotient shifting in}.
  logic [2*XLEN-1:0] acc_r;
  // Multiplicand for MUL/MULH, divisor for DIV/REM.
  logic [XLEN-1:0]   opnd_r;
  logic [AW-1:0]     adr_r;
  logic [XLEN-1:0]   wr_r;

  logic [2*XLEN-1:0] acc_nxt_s;
  logic [XLEN:0]     mul_sum_s;
  logic [XLEN:0]     div_shift_s;
  logic [XLEN:0]     div_diff_s;
  logic [XLEN-1:0]   a_mag_s;
  logic [XLEN-1:0]   b_mag_s;

`ifdef MULDIV_SIGNED_EN
  localparam logic [XLEN-1:0]   ONE_X  = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [2*XLEN-1:0] ONE_2X = {{(2*XLEN-1){1'b0}}, 1'b1};

  logic sa_s;
  logic sb_s;
  logic neg_s;
  logic neg_r;

  // Forms the final result from the magnitude result and the recorded sign.
  function automatic logic [XLEN-1:0] finalize(input logic [1:0] op,
                                               input logic [2*XLEN-1:0] acc,
                                               input logic neg);
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   res;
    prod = neg ? (~acc + ONE_2X) : acc;
    quo  = neg ? (~acc[XLEN-1:0] + ONE_X) : acc[XLEN-1:0];
    rem  = neg ? (~acc[2*XLEN-1:XLEN] + ONE_X) : acc[2*XLEN-1:XLEN];
    case (op)
      OP_MUL:  res = prod[XLEN-1:0];
      OP_MULH: res = prod[2*XLEN-1:XLEN];
      OP_DIV:  res = quo;
      OP_REM:  res = rem;
      default: res = quo;
    endcase
    return res;
  endfunction

  // Operand magnitudes and result sign captured at start.
  always_comb begin
    sa_s    = bus.op_signed & bus.operand_a[XLEN-1];
    sb_s    = bus.op_signed & bus.operand_b[XLEN-1];
    a_mag_s = sa_s ? (~bus.operand_a + ONE_X) : bus.operand_a;
    b_mag_s = sb_s ? (~bus.operand_b + ONE_X) : bus.operand_b;
    case (bus.op)
      OP_REM:  neg_s = sa_s;
      // A zero divisor must yield an all-ones quotient regardless of sign.
      OP_DIV:  neg_s = (sa_s ^ sb_s) & (|bus.operand_b);
      default: neg_s = sa_s ^ sb_s;
    endcase
  end
`else
  // Selects the result half of the work register.
  function automatic logic [XLEN-1:0] finalize(input logic [1:0] op,
                                               input logic [2*XLEN-1:0] acc);
    logic [XLEN-1:0] res;
    case (op)
      OP_MUL:  res = acc[XLEN-1:0];
      OP_MULH: res = acc[2*XLEN-1:XLEN];
      OP_DIV:  res = acc[XLEN-1:0];
      OP_REM:  res = acc[2*XLEN-1:XLEN];
      default: res = acc[XLEN-1:0];
    endcase
    return res;
  endfunction

  // Unsigned build: operands are used as-is.
  always_comb begin
    a_mag_s = bus.operand_a;
    b_mag_s = bus.operand_b;
  end
`endif

  // One shift-add or restoring-divide step of the work register.
  always_comb begin
    mul_sum_s   = {1'b0, acc_r[2*XLEN-1:XLEN]} + {1'b0, opnd_r};
    div_shift_s = {acc_r[2*XLEN-1:XLEN], acc_r[XLEN-1]};
    div_diff_s  = div_shift_s - {1'b0, opnd_r};
    if (op_r[1] == 1'b0) begin
      if (acc_r[0]) begin
        acc_nxt_s = {mul_sum_s, acc_r[XLEN-1:1]};
      end else begin
        acc_nxt_s = {1'b0, acc_r[2*XLEN-1:1]};
      end
    end else begin
      // The partial remainder always fits XLEN bits after the step, so
      // only the borrow bit of the XLEN+1-bit difference is examined.
      if (div_diff_s[XLEN] == 1'b0) begin
        acc_nxt_s = {div_diff_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};
      end else begin
        acc_nxt_s = {div_shift_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0};
      end
    end
  end

  // Control FSM, datapath registers and registered write-back outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      count_r <= {CW{1'b0}};
      op_r    <= 2'b00;
      rd_r    <= {AW{1'b0}};
      acc_r   <= {(2*XLEN){1'b0}};
      opnd_r  <= {XLEN{1'b0}};
      adr_r   <= {AW{1'b0}};
      wr_r    <= {XLEN{1'b0}};
`ifdef MULDIV_SIGNED_EN
      neg_r   <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            op_r    <= bus.op;
            rd_r    <= bus.rd_in;
            count_r <= {CW{1'b0}};
            state_r <= RUN;
`ifdef MULDIV_SIGNED_EN
            neg_r   <= neg_s;
`endif
            if (bus.op[1] == 1'b0) begin
              acc_r  <= {{XLEN{1'b0}}, b_mag_s};
              opnd_r <= a_mag_s;
            end else begin
              acc_r  <= {{XLEN{1'b0}}, a_mag_s};
              opnd_r <= b_mag_s;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          acc_r   <= acc_nxt_s;
          count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
          if (count_r == LAST_ITER) begin
            state_r <= DONE;
            adr_r   <= rd_r;
`ifdef MULDIV_SIGNED_EN
            wr_r    <= finalize(op_r, acc_nxt_s, neg_r);
`else
            wr_r    <= finalize(op_r, acc_nxt_s);
`endif
          end else begin
            state_r <= RUN;
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy       = (state_r != IDLE);
  assign bus.done       = (state_r == DONE);
  assign bus.regwrite   = (state_r == DONE);
  assign bus.adr_wr_reg = adr_r;
  assign bus.wr_data    = wr_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: table-driven self-checking bench for muldiv_unit (XLEN=64)
// plus hand-written sequences for mid-operation start, reset abort and
// back-to-back issue. Expected values depend on MULDIV_SIGNED_EN.
module tb_muldiv_unit;

  localparam int XLEN = 64;
  localparam int AW   = 5;
  localparam int LAT  = XLEN + 1;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MULH = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;
  localparam logic [1:0] OP_REM  = 2'b11;

  typedef struct {
    logic [1:0]      op;
    logic            sgn;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] exp;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  muldiv_unit_if #(.XLEN(XLEN), .AW(AW)) bus ();

  muldiv_unit #(.XLEN(XLEN), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%h required=0x%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic [1:0] op, input logic sgn,
                       input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input logic [AW-1:0] rd);
    bus.start     = st;
    bus.op        = op;
    bus.op_signed = sgn;
    bus.operand_a = a;
    bus.operand_b = b;
    bus.rd_in     = rd;
  endtask

  // Issue one operation, scramble inputs after acceptance, check latency/result.
  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    lat = 0;
    @(negedge clk);
    drive(1'b1, v.op, v.sgn, v.a, v.b, v.rd);
    @(posedge clk);
    #1;
    drive(1'b0, ~v.op, ~v.sgn, ~v.a, v.a, ~v.rd);
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (bus.regwrite) begin
        lat = k;
        break;
      end
    end
    check({tag, "_latency"}, 64'(lat), 64'(LAT));
    check({tag, "_data"}, bus.wr_data, v.exp);
    check({tag, "_adr"}, 64'(bus.adr_wr_reg), 64'(v.rd));
    check({tag, "_done"}, 64'(bus.done), 64'd1);
    @(negedge clk);
    check({tag, "_busy_fall"}, 64'(bus.busy), 64'd0);
    check({tag, "_data_hold"}, bus.wr_data, v.exp);
  endtask

  vec_t vecs[16];

  initial begin
    int pulses;
    int plat;
    int lat1;
    int lat2;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] d1;
    logic [XLEN-1:0] d2;
    checks   = 0;
    failures = 0;

    vecs[0]  = '{OP_MUL,  1'b0, 64'd7, 64'd6, 5'd3, 64'd42};
    vecs[1]  = '{OP_MULH, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd1, 64'd1};
    vecs[2]  = '{OP_MUL,  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd2, 64'hFFFF_FFFF_FFFF_FFFE};
    vecs[3]  = '{OP_DIV,  1'b0, 64'd100, 64'd7, 5'd5, 64'd14};
    vecs[4]  = '{OP_REM,  1'b0, 64'd100, 64'd7, 5'd6, 64'd2};
    vecs[5]  = '{OP_DIV,  1'b0, 64'd5, 64'd0, 5'd7, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[6]  = '{OP_REM,  1'b0, 64'd5, 64'd0, 5'd8, 64'd5};
    vecs[7]  = '{OP_MULH, 1'b0, 64'h1_0000_0000, 64'h1_0000_0000, 5'd0, 64'd1};
    vecs[12] = '{OP_MUL,  1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd13, 64'hFFFF_FFFF_FFFF_FFF2};
    vecs[13] = '{OP_REM,  1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 5'd31, 64'hFFFF_FFFF_FFFF_FFF9};
    vecs[15] = '{OP_DIV,  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1_0000_0000, 5'd15, 64'h0000_0000_FFFF_FFFF};
`ifdef MULDIV_SIGNED_EN
    vecs[8]  = '{OP_DIV,  1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd9,  64'hFFFF_FFFF_FFFF_FFFD};
    vecs[9]  = '{OP_REM,  1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd10, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[10] = '{OP_DIV,  1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd11, 64'h8000_0000_0000_0000};
    vecs[11] = '{OP_MULH, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd12, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[14] = '{OP_REM,  1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd14, 64'd0};
`else
    vecs[8]  = '{OP_DIV,  1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd9,  64'h7FFF_FFFF_FFFF_FFFC};
    vecs[9]  = '{OP_REM,  1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd10, 64'd1};
    vecs[10] = '{OP_DIV,  1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd11, 64'd0};
    vecs[11] = '{OP_MULH, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd12, 64'd1};
    vecs[14] = '{OP_REM,  1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd14, 64'h8000_0000_0000_0000};
`endif

    // Reset with start held high: reset must win.
    rst = 1'b1;
    drive(1'b1, OP_MUL, 1'b0, 64'd1, 64'd1, 5'd1);
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_regwrite", 64'(bus.regwrite), 64'd0);
    check("reset_adr", 64'(bus.adr_wr_reg), 64'd0);
    check("reset_wr_data", bus.wr_data, 64'd0);
    rst = 1'b0;
    drive(1'b0, OP_MUL, 1'b0, 64'd0, 64'd0, 5'd0);
    @(negedge clk);
    check("post_reset_busy", 64'(bus.busy), 64'd0);

    for (int i = 0; i < 16; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Extra starts during RUN and DONE must be ignored.
    @(negedge clk);
    drive(1'b1, OP_MUL, 1'b0, 64'd3, 64'd3, 5'd4);
    @(posedge clk);
    #1;
    drive(1'b0, OP_MUL, 1'b0, 64'd0, 64'd0, 5'd0);
    pulses = 0;
    plat   = 0;
    wdata  = 64'd0;
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      if (bus.regwrite) begin
        pulses++;
        plat  = k;
        wdata = bus.wr_data;
      end
      if (k == 10 || k == LAT) begin
        drive(1'b1, OP_DIV, 1'b0, 64'd50, 64'd5, 5'd9);
      end else begin
        drive(1'b0, OP_DIV, 1'b0, 64'd50, 64'd5, 5'd9);
      end
    end
    check("ignore_pulses", 64'(pulses), 64'd1);
    check("ignore_latency", 64'(plat), 64'(LAT));
    check("ignore_data", wdata, 64'd9);
    check("ignore_busy_after", 64'(bus.busy), 64'd0);
    check("ignore_data_hold", bus.wr_data, 64'd9);

    // Reset during RUN aborts without write-back.
    @(negedge clk);
    drive(1'b1, OP_MUL, 1'b0, 64'd3, 64'd3, 5'd4);
    @(posedge clk);
    #1;
    drive(1'b0, OP_MUL, 1'b0, 64'd0, 64'd0, 5'd0);
    pulses = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.regwrite) pulses++;
      if (k == 20) rst = 1'b1;
    end
    @(negedge clk);
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_wr_data", bus.wr_data, 64'd0);
    check("abort_adr", 64'(bus.adr_wr_reg), 64'd0);
    rst = 1'b0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (bus.regwrite) pulses++;
    end
    check("abort_no_writeback", 64'(pulses), 64'd0);

    // Back-to-back: second start at the earliest accepted edge.
    @(negedge clk);
    drive(1'b1, OP_MUL, 1'b0, 64'd7, 64'd6, 5'd3);
    @(posedge clk);
    #1;
    drive(1'b0, OP_MUL, 1'b0, 64'd0, 64'd0, 5'd0);
    lat1 = 0;
    lat2 = 0;
    d1   = 64'd0;
    d2   = 64'd0;
    for (int k = 1; k <= 140; k++) begin
      @(negedge clk);
      if (bus.regwrite) begin
        if (lat1 == 0) begin
          lat1 = k;
          d1   = bus.wr_data;
        end else begin
          lat2 = k;
          d2   = bus.wr_data;
        end
      end
      if (k == XLEN + 2) begin
        drive(1'b1, OP_MUL, 1'b0, 64'd5, 64'd5, 5'd7);
      end else begin
        drive(1'b0, OP_MUL, 1'b0, 64'd0, 64'd0, 5'd0);
      end
    end
    check("b2b_first_latency", 64'(lat1), 64'(LAT));
    check("b2b_first_data", d1, 64'd42);
    check("b2b_second_latency", 64'(lat2), 64'(2 * XLEN + 3));
    check("b2b_second_data", d2, 64'd25);
    check("b2b_second_adr", 64'(bus.adr_wr_reg), 64'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
